// File: rtl/id_scoreboard_ctrl.sv
// Decode-stage RAW/WAW interlock: per-register in-flight write counters gate ready_go,
// plus a stall-cycle counter and a sticky protocol-error flag.
module id_scoreboard_ctrl #(
    parameter int NREG   = 32,
    parameter int CNT_W  = 2,
    parameter int PERF_W = 32
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              flush,
    input  logic              ds_valid,
    input  logic [4:0]        ds_rs1,
    input  logic              ds_rs1_ren,
    input  logic [4:0]        ds_rs2,
    input  logic              ds_rs2_ren,
    input  logic [4:0]        ds_rd,
    input  logic              ds_rd_we,
    input  logic              ds_issue,
    input  logic              ws_rf_we,
    input  logic [4:0]        ws_rf_waddr,
    output logic              ds_ready_go,
    output logic [NREG-1:0]   busy_vec,
    output logic [PERF_W-1:0] stall_cnt,
    output logic              sb_err
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [NREG-1:0][CNT_W-1:0] cnt;
    logic [NREG-1:0]            inc, dec, uflow;
    logic                       hazard, issue_ok, issue_bad;

    always_comb begin
        hazard = (ds_rs1_ren && cnt[ds_rs1] != '0) ||
                 (ds_rs2_ren && cnt[ds_rs2] != '0) ||
                 (ds_rd_we && ds_rd != 5'd0 && cnt[ds_rd] == CNT_MAX);
        ds_ready_go = !ds_valid || !hazard;
        issue_ok    = ds_issue && ds_valid && ds_ready_go;
        issue_bad   = ds_issue && !(ds_valid && ds_ready_go);
    end

    // x0 never participates: its inc/dec/underflow terms stay 0 and its count stays 0.
    always_comb begin
        inc      = '0;
        dec      = '0;
        uflow    = '0;
        busy_vec = '0;
        for (int i = 1; i < NREG; i++) begin
            inc[i]      = issue_ok && ds_rd_we && ds_rd == i[4:0];
            dec[i]      = ws_rf_we && ws_rf_waddr == i[4:0];
            uflow[i]    = dec[i] && !inc[i] && cnt[i] == '0;
            busy_vec[i] = cnt[i] != '0;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cnt <= '0;
        end else if (flush) begin
            cnt <= '0;
        end else begin
            for (int i = 1; i < NREG; i++) begin
                if (inc[i] && !dec[i] && cnt[i] != CNT_MAX)
                    cnt[i] <= cnt[i] + 1'b1;
                else if (dec[i] && !inc[i] && cnt[i] != '0)
                    cnt[i] <= cnt[i] - 1'b1;
            end
            cnt[0] <= '0;
        end
    end

    // A flushed cycle discards its issue/WB, so it cannot raise a protocol error either.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            stall_cnt <= '0;
            sb_err    <= 1'b0;
        end else begin
            if (ds_valid && !ds_ready_go && !flush)
                stall_cnt <= stall_cnt + 1'b1;
            if (!flush && (issue_bad || (|uflow)))
                sb_err <= 1'b1;
        end
    end

endmodule

// File: doc/id_scoreboard_ctrl.md
Name: id_scoreboard_ctrl

Overview:
- RAW/WAW interlock controller for the decode stage of the 64-bit in-order pipeline.
- Keeps a per-register count of in-flight writes: incremented at ID issue, decremented at WB regfile write.
- Gates id_stage's ready_go so that no instruction reads a register that is still pending. The pipeline has no forwarding path.
- Also provides a stall performance counter and a sticky protocol-error flag.

Parameters:
- NREG, 32, number of architectural integer registers; x0 is never tracked.
- CNT_W, 2, width of each per-register in-flight counter; saturates at 2^CNT_W-1.
- PERF_W, 32, width of the stall-cycle counter.

Ports:
- clk  input  1  system clock, rising-edge.
- resetn  input  1  asynchronous, active-low reset.
- flush  input  1  pipeline flush; clears all pending state.
- ds_valid  input  1  decode stage holds a valid instruction.
- ds_rs1  input  5  source register 1 index.
- ds_rs1_ren  input  1  instruction reads rs1.
- ds_rs2  input  5  source register 2 index.
- ds_rs2_ren  input  1  instruction reads rs2.
- ds_rd  input  5  destination register index.
- ds_rd_we  input  1  instruction writes rd.
- ds_issue  input  1  ds_valid & ds_ready_go & es_allowin; the instruction leaves ID this cycle.
- ws_rf_we  input  1  WB regfile write enable (from ws_to_rf_bus).
- ws_rf_waddr  input  5  WB regfile write address.
- ds_ready_go  output  1  no hazard; decode may hand off to EX.
- busy_vec  output  NREG  bit i = count[i]!=0.
- stall_cnt  output  PERF_W  number of cycles with ds_valid & ~ds_ready_go.
- sb_err  output  1  sticky scoreboard protocol error.

Behaviour:
- State: count[1..NREG-1] (CNT_W bits each), stall_cnt, sb_err. count[0] is hardwired to 0.
- Async reset (resetn=0): all counts 0, busy_vec 0, stall_cnt 0, sb_err 0. After reset, ds_ready_go=1 whenever sources are clear.
- ds_ready_go is combinational and evaluated when ds_valid=1. It is 0 if any of the following holds:
  - ds_rs1_ren & count[ds_rs1]!=0
  - ds_rs2_ren & count[ds_rs2]!=0
  - ds_rd_we & ds_rd!=0 & count[ds_rd]==max (WAW saturation)
  Otherwise ds_ready_go=1. When ds_valid=0, ds_ready_go=1.
- No same-cycle bypass: a WB write in cycle N clears a hazard seen by ID only in cycle N+1, because the regfile writes at the clock edge.
- Per-register update at posedge:
  - inc = ds_issue & ds_rd_we & ds_rd==i.
  - dec = ws_rf_we & ws_rf_waddr==i.
  - inc&dec: count unchanged. inc only: count+1. dec only: count-1.
  - i=0 is ignored for both inc and dec.
- Underflow: dec with count[i]==0 leaves the count at 0 and sets sb_err.
- Illegal issue: ds_issue while ds_ready_go=0 (or ds_valid=0) is ignored (no increment) and sets sb_err.
- flush=1 at posedge: all counts go to 0, and flush overrides any issue or WB in the same cycle. stall_cnt and sb_err are unaffected.
- stall_cnt increments by 1 each cycle with ds_valid & ~ds_ready_go and wraps modulo 2^PERF_W. The increment is suppressed while flush=1.
- sb_err is sticky and cleared only by reset.
- busy_vec is a registered reflection of the counts; it is valid the cycle after the edge.
- Latency: issue at edge N makes the register busy from cycle N+1. WB at edge M frees it from cycle M+1.

Test Plan:
- Reset, then ds_valid=1, addi x2,x0,20 (rs1=0, rd=2), ds_issue=1 -> ds_ready_go=1; after the edge, busy_vec=0x4 and count[2]=1.
- Next cycle: addi x3,x2,5 (rs1=2) -> ds_ready_go=0 and stall_cnt increments each cycle. Drive ws_rf_we=1, waddr=2 -> ds_ready_go=1 in the cycle after that edge; stall_cnt equals the number of stalled cycles.
- Issue three writers to x5 with no WB -> count[5]=3. A fourth rd=x5 writer -> ds_ready_go=0 (saturation). One WB to x5 -> ready_go=1 next cycle.
- Same-cycle issue rd=x7 and WB waddr=7 with count[7]=1 -> count[7] stays 1. WB to x0 or issue with rd=x0 -> no state change, busy_vec bit 0 stays 0.
- Busy x2, x5; assert flush together with an issue to rd=x9 -> all counts 0, busy_vec=0 next cycle, sb_err=0.
- WB waddr=4 with count[4]=0 -> sb_err=1, count stays 0. Pulse resetn low mid-operation -> all state 0 immediately (asynchronous), including sb_err and stall_cnt.
